fix_vector_accumulator: RTL

- Downstream consumer of the fp16-to-fixed converter output. It accepts a stream of two's-complement fixed-point terms plus their NaN/sNaN/Inf flags over a valid/ready handshake.
- Terms are summed into a wider saturating accumulator. When a term tagged last is accepted, the block emits one result per vector, with sticky special-value flags and an element count.
- It forms the reduction stage of the fixed-point dot-product / sum datapath.

---
 rtl/fix_acc_pkg.sv | 56 +++++
 rtl/fix_sat_adder.sv | 35 +++
 rtl/fix_vector_accumulator.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fix_acc_pkg.sv
// rtl/fix_acc_pkg.sv - shared types, saturation limits and result-flag helper for the vector accumulator
//
// Contents:
//   acc_state_t    : ACCUM (taking terms) / HOLD (result pending)
//   acc_flags_t    : sticky per-vector flags
//   res_flags_t    : flags as presented with a result
//   sat_pos_limit  : 2^(w-1)-1 in the low w bits
//   sat_neg_limit  : -2^(w-1) in the low w bits
//   derive_result  : sticky flags -> result flags
package fix_acc_pkg;

  // Widest accumulator the limit helpers can describe.
  localparam int MAX_ACC_WIDTH = 128;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic nan;
    logic snan;
    logic pos_inf;
    logic neg_inf;
    logic overflow;
  } acc_flags_t;

  typedef struct packed {
    logic overflow;
    logic nan;
    logic snan;
    logic inf;
    logic inf_sign;
  } res_flags_t;

  function automatic logic [MAX_ACC_WIDTH-1:0] sat_pos_limit(input int w);
    return (MAX_ACC_WIDTH'(1) << (w - 1)) - MAX_ACC_WIDTH'(1);
  endfunction

  function automatic logic [MAX_ACC_WIDTH-1:0] sat_neg_limit(input int w);
    return MAX_ACC_WIDTH'(1) << (w - 1);
  endfunction

  // Opposite infinities collapse to NaN; a lone infinity survives only
  // when no NaN of any kind was seen.
  function automatic res_flags_t derive_result(input acc_flags_t f);
    res_flags_t r;
    r.overflow = f.overflow;
    r.nan      = f.nan | (f.pos_inf & f.neg_inf);
    r.snan     = f.snan;
    r.inf      = (f.pos_inf ^ f.neg_inf) & ~r.nan;
    r.inf_sign = f.neg_inf;
    return r;
  endfunction

endpackage

// File: rtl/fix_sat_adder.sv
// rtl/fix_sat_adder.sv - combinational signed adder clamping to the ACC_WIDTH range
//
// Ports:
//   a_i, b_i    : signed ACC_WIDTH operands
//   sum_o       : a_i + b_i, clamped to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]
//   overflow_o  : high when the clamp was applied
module fix_sat_adder
  import fix_acc_pkg::*;
#(
  parameter int ACC_WIDTH = 48
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 overflow_o
);

  localparam logic [MAX_ACC_WIDTH-1:0] POS_FULL = sat_pos_limit(ACC_WIDTH);
  localparam logic [MAX_ACC_WIDTH-1:0] NEG_FULL = sat_neg_limit(ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0]     POS_LIM  = POS_FULL[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0]     NEG_LIM  = NEG_FULL[ACC_WIDTH-1:0];

  logic [ACC_WIDTH-1:0] raw_sum;

  assign raw_sum = a_i + b_i;

  // Two's-complement overflow: operands agree in sign, result does not.
  assign overflow_o = (a_i[ACC_WIDTH-1] == b_i[ACC_WIDTH-1]) &&
                      (raw_sum[ACC_WIDTH-1] != a_i[ACC_WIDTH-1]);

  // The overflow direction follows the shared operand sign.
  assign sum_o = !overflow_o         ? raw_sum :
                 a_i[ACC_WIDTH-1]    ? NEG_LIM : POS_LIM;

endmodule

// File: rtl/fix_vector_accumulator.sv
// rtl/fix_vector_accumulator.sv - per-vector saturating sum of fixed-point terms with sticky special-value flags
//
// Ports:
//   clk_i, rst_ni                  : clock, asynchronous active-low reset
//   clear_i                        : synchronous abort of partial vector / pending result
//   in_valid_i / in_ready_o        : term handshake
//   in_data_i, in_last_i           : signed term, final element marker
//   in_nan_i, in_snan_i, in_inf_i  : term special-value tags (inf sign = in_data_i MSB)
//   out_valid_o / out_ready_i      : result handshake
//   out_sum_o, out_count_o         : finite-term sum, element count (saturating)
//   out_overflow_o, out_nan_o,
//   out_snan_o, out_inf_o,
//   out_inf_sign_o                 : result flags
module fix_vector_accumulator
  import fix_acc_pkg::*;
#(
  parameter int FIXED_OP_WIDTH = 40,
  parameter int ACC_WIDTH      = 48,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clear_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [FIXED_OP_WIDTH-1:0] in_data_i,
  input  logic                      in_last_i,
  input  logic                      in_nan_i,
  input  logic                      in_snan_i,
  input  logic                      in_inf_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ACC_WIDTH-1:0]      out_sum_o,
  output logic [COUNT_WIDTH-1:0]    out_count_o,
  output logic                      out_overflow_o,
  output logic                      out_nan_o,
  output logic                      out_snan_o,
  output logic                      out_inf_o,
  output logic                      out_inf_sign_o
);

  acc_state_t state, state_nxt;

  logic [ACC_WIDTH-1:0]   acc, acc_upd;
  logic [COUNT_WIDTH-1:0] count, count_upd;
  acc_flags_t             flags, flags_upd;

  logic [ACC_WIDTH-1:0]   sum_q;
  logic [COUNT_WIDTH-1:0] count_q;
  res_flags_t             res_q;

  logic                   accept;
  logic                   term_special;
  logic [ACC_WIDTH-1:0]   term_ext;
  logic [ACC_WIDTH-1:0]   add_sum;
  logic                   add_ovf;

  assign accept       = in_valid_i & in_ready_o;
  assign term_special = in_nan_i | in_snan_i | in_inf_i;
  assign term_ext     = ACC_WIDTH'($signed(in_data_i));

  fix_sat_adder #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat_adder (
    .a_i        (acc),
    .b_i        (term_ext),
    .sum_o      (add_sum),
    .overflow_o (add_ovf)
  );

  // Post-accept values of the running state; only committed on accept.
  always_comb begin
    acc_upd   = acc;
    flags_upd = flags;
    count_upd = (count == '1) ? count : count + COUNT_WIDTH'(1);
    if (term_special) begin
      // Special terms contribute nothing to the finite sum.
      flags_upd.nan     = flags.nan | in_nan_i | in_snan_i;
      flags_upd.snan    = flags.snan | in_snan_i;
      flags_upd.pos_inf = flags.pos_inf | (in_inf_i & ~in_data_i[FIXED_OP_WIDTH-1]);
      flags_upd.neg_inf = flags.neg_inf | (in_inf_i & in_data_i[FIXED_OP_WIDTH-1]);
    end else if (!flags.overflow) begin
      // After the first saturation the accumulator is frozen at the limit.
      acc_upd = add_sum;
      if (add_ovf) begin
        flags_upd.overflow = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    case (state)
      ACCUM: begin
        in_ready_o = ~clear_i;
        if (!clear_i && accept && in_last_i) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid_o = 1'b1;
        if (clear_i || out_ready_i) begin
          state_nxt = ACCUM;
        end
      end
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc     <= '0;
      count   <= '0;
      flags   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      res_q   <= '0;
    end else if (clear_i) begin
      acc     <= '0;
      count   <= '0;
      flags   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      res_q   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_upd;
            count <= count_upd;
            flags <= flags_upd;
            if (in_last_i) begin
              sum_q   <= acc_upd;
              count_q <= count_upd;
              res_q   <= derive_result(flags_upd);
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            acc     <= '0;
            count   <= '0;
            flags   <= '0;
            sum_q   <= '0;
            count_q <= '0;
            res_q   <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum_o      = sum_q;
  assign out_count_o    = count_q;
  assign out_overflow_o = res_q.overflow;
  assign out_nan_o      = res_q.nan;
  assign out_snan_o     = res_q.snan;
  assign out_inf_o      = res_q.inf;
  assign out_inf_sign_o = res_q.inf_sign;

endmodule
